// File: rtl/flex_timer.sv
// -----------------------------------------------------------------------------
// flex_timer
//   Loadable down-counting timer with one-shot and periodic (auto-reload)
//   modes. It is used for pixel-interval, line-blanking and timeout generation.
//   A load starts or restarts the timer. count_enable pauses it. An expiry is
//   reported as a one-cycle registered pulse.
//
// Parameters
//   NUM_CNT_BITS : width of the count, load and reload registers
//   DECREMENT    : amount subtracted per enabled cycle (1 .. 2^NUM_CNT_BITS-1)
//
// Ports
//   clk          in   system clock, rising-edge
//   n_rst        in   synchronous active-low reset
//   clear        in   synchronous abort back to IDLE (below reset in priority)
//   load         in   start/restart request; load_val==0 expires immediately
//   load_val     in   start value captured with load
//   periodic     in   mode captured with load: 1 = auto-reload, 0 = one-shot
//   count_enable in   decrement enable while running; 0 holds the count
//   count_out    out  registered remaining count
//   expired_flag out  registered one-cycle expiry pulse
//   busy         out  registered; high exactly while the FSM is in RUN
//
// Control handshake: none. load and clear are level-sampled on every edge.
// Priority at each edge is reset > clear > load > count.
// -----------------------------------------------------------------------------
module flex_timer #(
   parameter int NUM_CNT_BITS = 4,
   parameter int DECREMENT    = 1
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    load,
   input  logic [NUM_CNT_BITS-1:0] load_val,
   input  logic                    periodic,
   input  logic                    count_enable,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    expired_flag,
   output logic                    busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // DECREMENT in both widths. The wide copy keeps the terminal comparison
   // free of truncation when DECREMENT is close to 2^NUM_CNT_BITS.
   localparam logic [NUM_CNT_BITS-1:0] DEC_N  = NUM_CNT_BITS'(DECREMENT);
   localparam logic [NUM_CNT_BITS:0]   DEC_N1 = (NUM_CNT_BITS + 1)'(DECREMENT);

   state_e                  state_q, state_d;
   logic [NUM_CNT_BITS-1:0] count_q, count_d;
   logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
   logic                    periodic_q, periodic_d;
   logic                    expired_q, expired_d;
   logic                    terminal;

   // The terminal cycle is the one in which the next subtraction would reach or
   // pass zero. Saturating there means count_out never wraps.
   assign terminal = ({1'b0, count_q} <= DEC_N1);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      reload_d   = reload_q;
      periodic_d = periodic_q;
      expired_d  = 1'b0;

      if (clear) begin
         // Abort: the count is discarded. reload and mode are kept.
         state_d = IDLE;
         count_d = '0;
      end else if (load) begin
         if (load_val != '0) begin
            // Start or restart. Any expiry due this cycle is suppressed.
            state_d    = RUN;
            count_d    = load_val;
            reload_d   = load_val;
            periodic_d = periodic;
         end else begin
            // A zero interval expires at once, whatever the mode.
            state_d   = IDLE;
            count_d   = '0;
            expired_d = 1'b1;
         end
      end else if (state_q == RUN && count_enable) begin
         if (terminal) begin
            expired_d = 1'b1;
            if (periodic_q) begin
               count_d = reload_q;
            end else begin
               count_d = '0;
               state_d = IDLE;
            end
         end else begin
            count_d = count_q - DEC_N;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         reload_q   <= '0;
         periodic_q <= 1'b0;
         expired_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         reload_q   <= reload_d;
         periodic_q <= periodic_d;
         expired_q  <= expired_d;
      end
   end

   assign count_out    = count_q;
   assign expired_flag = expired_q;
   // busy is the registered FSM state. It doubles as the state debug view.
   assign busy         = (state_q == RUN);

endmodule

// File: tb/tb_flex_timer.sv
// -----------------------------------------------------------------------------
// tb_flex_timer
//   Two flex_timer instances with NUM_CNT_BITS=4 share one set of stimulus.
//   Instance 0 uses DECREMENT=1 and instance 1 uses DECREMENT=3. A behavioural
//   model for each one is checked on every falling edge. Directed sequences
//   also pin hand-computed values. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_flex_timer;

   localparam int W = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         n_rst = 1'b0;
   logic         clear = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         periodic = 1'b0;
   logic         count_enable = 1'b0;

   logic [W-1:0] c0, c1;
   logic         e0, e1, b0, b1;

   flex_timer #(.NUM_CNT_BITS(W), .DECREMENT(1)) dut0 (
      .clk(clk), .n_rst(n_rst), .clear(clear), .load(load),
      .load_val(load_val), .periodic(periodic), .count_enable(count_enable),
      .count_out(c0), .expired_flag(e0), .busy(b0)
   );

   flex_timer #(.NUM_CNT_BITS(W), .DECREMENT(3)) dut1 (
      .clk(clk), .n_rst(n_rst), .clear(clear), .load(load),
      .load_val(load_val), .periodic(periodic), .count_enable(count_enable),
      .count_out(c1), .expired_flag(e1), .busy(b1)
   );

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Remaining time is held as a signed integer. Expiry is the step whose
   // remaining time would fall to zero or below.
   int dec[2] = '{1, 3};
   int m_cnt[2], m_rel[2];
   bit m_run[2], m_per[2], m_exp[2];
   bit model_valid = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         for (int k = 0; k < 2; k++) begin
            if (!n_rst) begin
               m_cnt[k] = 0; m_rel[k] = 0; m_run[k] = 0; m_per[k] = 0; m_exp[k] = 0;
            end else if (clear) begin
               m_cnt[k] = 0; m_run[k] = 0; m_exp[k] = 0;
            end else if (load) begin
               if (int'(load_val) == 0) begin
                  m_cnt[k] = 0; m_run[k] = 0; m_exp[k] = 1;
               end else begin
                  m_cnt[k] = int'(load_val); m_rel[k] = int'(load_val);
                  m_per[k] = periodic; m_run[k] = 1; m_exp[k] = 0;
               end
            end else if (m_run[k] && count_enable) begin
               int remaining;
               remaining = m_cnt[k] - dec[k];
               if (remaining <= 0) begin
                  m_exp[k] = 1;
                  if (m_per[k]) m_cnt[k] = m_rel[k];
                  else begin
                     m_cnt[k] = 0; m_run[k] = 0;
                  end
               end else begin
                  m_cnt[k] = remaining; m_exp[k] = 0;
               end
            end else begin
               m_exp[k] = 0;
            end
         end
         if (!n_rst) model_valid = 1'b1;
      end
   end

   // ---------------- scoreboard compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (model_valid) begin
            chk("m0_count", 32'(c0), 32'(m_cnt[0]));
            chk("m0_exp",   32'(e0), 32'(m_exp[0]));
            chk("m0_busy",  32'(b0), 32'(m_run[0]));
            chk("m1_count", 32'(c1), 32'(m_cnt[1]));
            chk("m1_exp",   32'(e1), 32'(m_exp[1]));
            chk("m1_busy",  32'(b1), 32'(m_run[1]));
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int v, input bit per);
      load = 1'b1; load_val = W'(v); periodic = per;
      tick();
      load = 1'b0;
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int exp5[6];
      int exp7[4];
      exp5 = '{5, 4, 3, 2, 1, 0};
      exp7 = '{7, 4, 1, 0};

      // Reset held for 2 cycles with a load pending; the load must be ignored.
      n_rst = 1'b0; load = 1'b1; load_val = 4'd5; count_enable = 1'b1;
      tick(); tick();
      chk("rst_count", 32'(c0), 0);
      chk("rst_busy",  32'(b0), 0);
      chk("rst_exp",   32'(e0), 0);
      n_rst = 1'b1; load = 1'b0;
      tick();
      chk("rst_idle_count", 32'(c0), 0);
      chk("rst_idle_busy",  32'(b0), 0);

      // One-shot with DECREMENT=1: 5,4,3,2,1,0 and a single pulse at 0.
      count_enable = 1'b1;
      do_load(5, 0);
      for (int i = 0; i < 6; i++) begin
         chk("os_count", 32'(c0), 32'(exp5[i]));
         chk("os_exp",   32'(e0), (i == 5) ? 32'd1 : 32'd0);
         chk("os_busy",  32'(b0), (i == 5) ? 32'd0 : 32'd1);
         if (i < 5) tick();
      end
      tick();
      chk("os_no_repeat", 32'(e0), 0);

      // DECREMENT=3 one-shot: 7,4,1,0 with no wrap to 14.
      do_load(7, 0);
      for (int i = 0; i < 4; i++) begin
         chk("d3_count", 32'(c1), 32'(exp7[i]));
         chk("d3_exp",   32'(e1), (i == 3) ? 32'd1 : 32'd0);
         if (i < 3) tick();
      end
      tick();
      chk("d3_stays0", 32'(c1), 0);

      // Periodic 3: 3,2,1,3(pulse),2 then pause 4 cycles, then resume 1,3(pulse).
      do_load(3, 1);
      chk("per_c3", 32'(c0), 3);
      tick(); chk("per_c2", 32'(c0), 2);
      tick(); chk("per_c1", 32'(c0), 1);
      tick(); chk("per_reload", 32'(c0), 3); chk("per_exp", 32'(e0), 1);
      tick(); chk("per_c2b", 32'(c0), 2); chk("per_noexp", 32'(e0), 0);
      count_enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("pause_hold", 32'(c0), 2);
         chk("pause_noexp", 32'(e0), 0);
      end
      count_enable = 1'b1;
      tick(); chk("resume_c1", 32'(c0), 1);
      tick(); chk("resume_reload", 32'(c0), 3); chk("resume_exp", 32'(e0), 1);
      chk("resume_busy", 32'(b0), 1);

      // Restart: load 9, three decrements, then reload 2 -> expiry 2 cycles on.
      do_load(9, 0);
      tick(); tick(); tick();
      chk("rs_c6", 32'(c0), 6);
      do_load(2, 0);
      chk("rs_c2", 32'(c0), 2); chk("rs_noexp", 32'(e0), 0);
      tick(); chk("rs_c1", 32'(c0), 1); chk("rs_noexp2", 32'(e0), 0);
      tick(); chk("rs_c0", 32'(c0), 0); chk("rs_exp", 32'(e0), 1);
      tick(); chk("rs_single", 32'(e0), 0);

      // Clear at count 4 discards the count without a pulse.
      do_load(9, 1);
      for (int i = 0; i < 5; i++) tick();
      chk("clr_pre", 32'(c0), 4);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_count", 32'(c0), 0); chk("clr_busy", 32'(b0), 0); chk("clr_exp", 32'(e0), 0);
      tick(); chk("clr_exp2", 32'(e0), 0);

      // A zero load expires immediately, even in periodic mode.
      do_load(0, 1);
      chk("z_exp", 32'(e0), 1); chk("z_busy", 32'(b0), 0); chk("z_count", 32'(c0), 0);
      tick(); chk("z_exp_once", 32'(e0), 0); chk("z_busy2", 32'(b0), 0);

      // Randomized phase, checked by the model on every cycle.
      for (int i = 0; i < 3000; i++) begin
         n_rst        = ($urandom_range(0, 199) != 0);
         clear        = ($urandom_range(0, 63) == 0);
         load         = ($urandom_range(0, 9) == 0);
         load_val     = W'($urandom_range(0, 15));
         periodic     = $urandom_range(0, 1);
         count_enable = ($urandom_range(0, 3) != 0);
         tick();
      end
      load = 1'b0; clear = 1'b0; n_rst = 1'b1;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
